// File: rtl/pipelined_addsub_pkg.sv
// pipelined_addsub_pkg: shared defaults and segment-width rule for the pipelined adder/subtractor
package pipelined_addsub_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;

    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/seg_ripple_adder.sv
// seg_ripple_adder: combinational SEG-bit ripple of full adders
module seg_ripple_adder
    import pipelined_addsub_pkg::*;
#(
    parameter int SEG = seg_width(DEF_WIDTH, DEF_STAGES)
) (
    input  logic [SEG-1:0] a_seg,
    input  logic [SEG-1:0] b_seg,
    input  logic           c_in,
    output logic [SEG-1:0] s_seg,
    output logic           c_out
);

    logic cy;

    // ripple the carry bit by bit through the segment
    always_comb begin
        cy    = c_in;
        s_seg = '0;
        for (int i = 0; i < SEG; i++) begin
            s_seg[i] = a_seg[i] ^ b_seg[i] ^ cy;
            cy       = (a_seg[i] & b_seg[i]) | (cy & (a_seg[i] ^ b_seg[i]));
        end
        c_out = cy;
    end

endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit add/sub split into STAGES carry-chained segments, one per clock stage
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG = seg_width(WIDTH, STAGES);
    localparam int L   = STAGES - 1;

    if (STAGES < 1 || WIDTH % STAGES != 0) begin : g_bad_cfg
        $error("pipelined_addsub: WIDTH must be a positive multiple of STAGES");
    end

    logic                               adv;
    logic [STAGES-1:0]                  valid_q, valid_d, v_in;
    logic [STAGES-1:0]                  c_q, c_d, c_in, seg_c;
    logic [STAGES-1:0][WIDTH-1:0]       a_q, a_d, a_in;
    logic [STAGES-1:0][WIDTH-1:0]       bb_q, bb_d, bb_in;
    logic [STAGES-1:0][WIDTH-1:0]       r_q, r_d, r_in;
    logic [STAGES-1:0][SEG-1:0]         seg_s;

    // stage inputs: operand prep feeds stage 0, every later stage reads its predecessor's registers
    always_comb begin
        v_in  = '0;
        c_in  = '0;
        a_in  = '0;
        bb_in = '0;
        r_in  = '0;
        v_in[0]  = in_valid;
        a_in[0]  = a;
        bb_in[0] = sub ? ~b : b;
        c_in[0]  = sub | cin;
        for (int k = 1; k < STAGES; k++) begin
            v_in[k]  = valid_q[k-1];
            a_in[k]  = a_q[k-1];
            bb_in[k] = bb_q[k-1];
            c_in[k]  = c_q[k-1];
            r_in[k]  = r_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        seg_ripple_adder #(.SEG(SEG)) u_add (
            .a_seg (a_in[k][k*SEG +: SEG]),
            .b_seg (bb_in[k][k*SEG +: SEG]),
            .c_in  (c_in[k]),
            .s_seg (seg_s[k]),
            .c_out (seg_c[k])
        );
    end

    // whole pipe advances together; a stalled output freezes every stage
    always_comb begin
        adv     = !valid_q[L] | out_ready;
        valid_d = adv ? v_in  : valid_q;
        a_d     = adv ? a_in  : a_q;
        bb_d    = adv ? bb_in : bb_q;
        c_d     = adv ? seg_c : c_q;
        r_d     = adv ? r_in  : r_q;
        if (adv) begin
            for (int k = 0; k < STAGES; k++) r_d[k][k*SEG +: SEG] = seg_s[k];
        end
    end

    // pipeline registers, all cleared by reset so outputs are never X
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            c_q     <= '0;
            a_q     <= '0;
            bb_q    <= '0;
            r_q     <= '0;
        end else begin
            valid_q <= valid_d;
            c_q     <= c_d;
            a_q     <= a_d;
            bb_q    <= bb_d;
            r_q     <= r_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = valid_q[L];
    assign sum       = r_q[L];
    assign cout      = c_q[L];
    assign ovf       = (a_q[L][WIDTH-1] == bb_q[L][WIDTH-1]) & (r_q[L][WIDTH-1] != a_q[L][WIDTH-1]);

endmodule
